// File: rtl/tcb_lite_pkg.sv
// TCB lite shared types and byte-lane helpers.
// Used by subordinate endpoints and by manager-side models.
package tcb_lite_pkg;

    localparam int TCB_DW = 32;
    localparam int TCB_BW = TCB_DW / 8;
    localparam int TCB_AW = 32;
    localparam int TCB_CW = 4;

    typedef enum logic [1:0] {
        TCB_SIZ_B = 2'd0,
        TCB_SIZ_H = 2'd1,
        TCB_SIZ_W = 2'd2,
        TCB_SIZ_D = 2'd3
    } tcb_siz_e;

    typedef struct packed {
        logic              lck;
        logic              ndn;
        logic              wen;
        logic [TCB_CW-1:0] ctl;
        logic [TCB_AW-1:0] adr;
        tcb_siz_e          siz;
        logic [TCB_BW-1:0] byt;
        logic [TCB_DW-1:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic [TCB_DW-1:0] rdt;
        logic              sts;
        logic              err;
    } tcb_rsp_t;

    // Number of active bytes; the unsupported 8-byte size is capped at the bus width.
    function automatic int tcb_siz_bytes(input tcb_siz_e siz);
        case (siz)
            TCB_SIZ_B: return 1;
            TCB_SIZ_H: return 2;
            default:   return TCB_BW;
        endcase
    endfunction

    function automatic logic [1:0] tcb_lane_base(input logic [1:0] adr_lo, input tcb_siz_e siz);
        case (siz)
            TCB_SIZ_B: return adr_lo;
            TCB_SIZ_H: return {adr_lo[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic [TCB_DW-1:0] tcb_low_mask(input tcb_siz_e siz);
        logic [TCB_DW-1:0] m;
        m = '0;
        for (int i = 0; i < tcb_siz_bytes(siz); i++) begin
            m = m | (32'h0000_00FF << (8 * i));
        end
        return m;
    endfunction

    // byt[i] enables the i-th byte of the transfer, which lands on lane base+i.
    function automatic logic [TCB_BW-1:0] tcb_lane_mask(input logic [1:0] adr_lo,
                                                        input tcb_siz_e siz,
                                                        input logic [TCB_BW-1:0] byt);
        logic [TCB_BW-1:0] m;
        int                base;
        m    = '0;
        base = int'(tcb_lane_base(adr_lo, siz));
        for (int i = 0; i < tcb_siz_bytes(siz); i++) begin
            if (byt[2'(i)]) begin
                m[2'(base + i)] = 1'b1;
            end
        end
        return m;
    endfunction

    // Reverse byte order within the low 2**siz bytes; upper bytes pass through.
    function automatic logic [TCB_DW-1:0] tcb_endian_swap(input logic [TCB_DW-1:0] dat,
                                                          input tcb_siz_e siz);
        logic [TCB_DW-1:0] r;
        int                n;
        n = tcb_siz_bytes(siz);
        r = dat & ~tcb_low_mask(siz);
        for (int i = 0; i < n; i++) begin
            r = r | (((dat >> (8 * (n - 1 - i))) & 32'h0000_00FF) << (8 * i));
        end
        return r;
    endfunction

endpackage

// File: rtl/tcb_lite_if.sv
// TCB lite point-to-point interface with manager and subordinate views.
interface tcb_lite_if #(
    parameter int DLY = 1
) ();
    import tcb_lite_pkg::*;

    logic     vld;
    logic     rdy;
    tcb_req_t req;
    tcb_rsp_t rsp;
    logic [2:0] cfg_dly;

    assign cfg_dly = 3'(DLY);

    modport man (output vld, output req, input rdy, input rsp, input cfg_dly);
    modport sub (input vld, input req, input cfg_dly, output rdy, output rsp);
endinterface

// File: rtl/tcb_lite_lib_delay.sv
// DLY-stage register pipeline with synchronous clear.
// Payload is zeroed when not valid so the last stage can drive a bus directly.
module tcb_lite_lib_delay #(
    parameter int unsigned W   = 1,
    parameter int unsigned DLY = 1
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);
    logic [DLY-1:0] r_vld;
    logic [W-1:0]   r_dat [DLY];

    // Shift valid and payload one stage per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < int'(DLY); i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld    <= (r_vld << 1) | DLY'(i_vld);
            r_dat[0] <= i_vld ? i_dat : '0;
            for (int i = 1; i < int'(DLY); i++) begin
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign o_vld = r_vld[DLY-1];
    assign o_dat = r_dat[DLY-1];
endmodule

// File: rtl/tcb_lite_lib_memory_chk.sv
// Configuration checks for the TCB lite memory endpoint.
module tcb_lite_lib_memory_chk #(
    parameter int unsigned DLY = 1
)(
    input logic       clk,
    input logic       rst,
    input logic [2:0] i_cfg_dly
);
    // Latency must be in range and match the delay the bus was configured for.
    always @(posedge clk) begin
        if (!rst) begin
            assert (DLY >= 1 && DLY <= 4)
                else $error("tcb_lite_lib_memory: DLY=%0d out of range", DLY);
            assert (i_cfg_dly == 3'(DLY))
                else $error("tcb_lite_lib_memory: DLY=%0d, interface delay %0d", DLY, i_cfg_dly);
        end
    end
endmodule

// File: rtl/tcb_lite_lib_memory.sv
// TCB lite subordinate memory: byte-enabled RAM with fixed-latency responses.
// Data on the bus is right-justified: transfer byte i maps to address base+i.
module tcb_lite_lib_memory
    import tcb_lite_pkg::*;
#(
    parameter int unsigned SIZ     = 4096,
    parameter int unsigned DLY     = 1,
    parameter bit          ERR_MIS = 1'b1
)(
    input  logic    clk,
    input  logic    rst,
    tcb_lite_if.sub sub
);
    localparam int unsigned ADR_M = $clog2(SIZ);
    localparam int unsigned WORDS = SIZ / TCB_BW;
    localparam int unsigned IDX_W = ADR_M - 2;

    logic              w_trn;
    logic              w_oor;
    logic              w_mis;
    logic              w_bad_siz;
    logic              w_err;
    logic [1:0]        w_base;
    logic [IDX_W-1:0]  w_idx;
    logic [TCB_BW-1:0] w_mask;
    logic [TCB_DW-1:0] w_wdt_lane;
    logic [TCB_DW-1:0] w_rdt_word;
    logic [TCB_DW-1:0] w_rdt_low;
    logic [TCB_DW-1:0] w_rdt;
    logic              w_dly_vld;
    logic [TCB_DW:0]   w_dly_dat;
    logic              w_unused_ok;

    assign sub.rdy = !rst;
    assign w_trn   = sub.vld && !rst;
    assign w_idx   = sub.req.adr[ADR_M-1:2];

    if (ADR_M < TCB_AW) begin : g_oor
        assign w_oor = |sub.req.adr[TCB_AW-1:ADR_M];
    end else begin : g_no_oor
        assign w_oor = 1'b0;
    end

    // Decode, lane steering and read-data formatting.
    always_comb begin
        w_base     = tcb_lane_base(sub.req.adr[1:0], sub.req.siz);
        w_bad_siz  = (sub.req.siz == TCB_SIZ_D);
        w_mis      = (w_base != sub.req.adr[1:0]);
        w_err      = w_oor || w_bad_siz || (ERR_MIS && w_mis);
        w_mask     = '0;
        w_wdt_lane = (sub.req.ndn ? tcb_endian_swap(sub.req.wdt, sub.req.siz) : sub.req.wdt)
                     << {w_base, 3'b000};
        w_rdt_low  = (w_rdt_word >> {w_base, 3'b000}) & tcb_low_mask(sub.req.siz);
        w_rdt      = '0;
        if (w_trn && sub.req.wen && !w_err) begin
            w_mask = tcb_lane_mask(sub.req.adr[1:0], sub.req.siz, sub.req.byt);
        end else begin
            w_mask = '0;
        end
        if (sub.req.wen || w_err) begin
            w_rdt = '0;
        end else if (sub.req.ndn) begin
            w_rdt = tcb_endian_swap(w_rdt_low, sub.req.siz);
        end else begin
            w_rdt = w_rdt_low;
        end
    end

    for (genvar g = 0; g < TCB_BW; g++) begin : g_lane
        logic [7:0] r_mem [WORDS];

        // Byte-lane write port; contents survive reset.
        always_ff @(posedge clk) begin
            if (w_mask[g]) begin
                r_mem[w_idx] <= w_wdt_lane[8*g +: 8];
            end
        end

        assign w_rdt_word[8*g +: 8] = r_mem[w_idx];
    end

    tcb_lite_lib_delay #(
        .W   (TCB_DW + 1),
        .DLY (DLY)
    ) u_dly (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_trn),
        .i_dat ({w_rdt, w_err}),
        .o_vld (w_dly_vld),
        .o_dat (w_dly_dat)
    );

    assign sub.rsp.rdt = w_dly_dat[TCB_DW:1];
    assign sub.rsp.err = w_dly_dat[0];
    assign sub.rsp.sts = 1'b0;

    tcb_lite_lib_memory_chk #(
        .DLY (DLY)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .i_cfg_dly (sub.cfg_dly)
    );

    assign w_unused_ok = ^{sub.req.lck, sub.req.ctl, w_dly_vld};
endmodule

// File: tb/tb_tcb_lite_lib_memory.sv
// Directed bench for tcb_lite_lib_memory with a DLY=1 and a DLY=3 instance.
module tb_tcb_lite_lib_memory;
    import tcb_lite_pkg::*;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    tcb_lite_if #(.DLY(1)) if1 ();
    tcb_lite_if #(.DLY(3)) if3 ();

    tcb_lite_lib_memory #(.SIZ(4096), .DLY(1), .ERR_MIS(1'b1)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .sub (if1)
    );

    tcb_lite_lib_memory #(.SIZ(4096), .DLY(3), .ERR_MIS(1'b1)) u_dut3 (
        .clk (clk),
        .rst (rst3),
        .sub (if3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of request fields on instance sel (1 or 3), then advance a clock.
    task automatic drv(input int sel, input logic vld, input logic wen, input logic ndn,
                       input logic [31:0] adr, input logic [1:0] siz,
                       input logic [3:0] byt, input logic [31:0] wdt);
        if (sel == 1) begin
            if1.vld     = vld;
            if1.req.lck = 1'b0;
            if1.req.ctl = 4'h0;
            if1.req.wen = wen;
            if1.req.ndn = ndn;
            if1.req.adr = adr;
            if1.req.siz = tcb_siz_e'(siz);
            if1.req.byt = byt;
            if1.req.wdt = wdt;
        end else begin
            if3.vld     = vld;
            if3.req.lck = 1'b0;
            if3.req.ctl = 4'h0;
            if3.req.wen = wen;
            if3.req.ndn = ndn;
            if3.req.adr = adr;
            if3.req.siz = tcb_siz_e'(siz);
            if3.req.byt = byt;
            if3.req.wdt = wdt;
        end
        tick();
    endtask

    initial begin
        rst1 = 1'b1;
        rst3 = 1'b1;
        drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 32'h0);
        drv(3, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 32'h0);
        chk("rdy_init_rst", {31'b0, if1.rdy}, 32'h0);
        rst1 = 1'b0;
        rst3 = 1'b0;

        // ---------------- DLY=1 instance ----------------
        drv(1, 1'b1, 1'b1, 1'b0, 32'h40, 2'd2, 4'hF, 32'h1234_5678);
        rst1 = 1'b1;
        #1;
        chk("rdy_rst_assert", {31'b0, if1.rdy}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drv(1, 1'b1, 1'b1, 1'b0, 32'h40, 2'd2, 4'hF, 32'hFFFF_FFFF);
            chk("rst_rdy", {31'b0, if1.rdy}, 32'h0);
            chk("rst_rdt", if1.rsp.rdt, 32'h0);
            chk("rst_err", {31'b0, if1.rsp.err}, 32'h0);
        end
        rst1 = 1'b0;
        #1;
        chk("rdy_post_rst", {31'b0, if1.rdy}, 32'h1);
        drv(1, 1'b1, 1'b0, 1'b0, 32'h40, 2'd2, 4'hF, 32'h0);
        chk("rst_no_write", if1.rsp.rdt, 32'h1234_5678);

        drv(1, 1'b1, 1'b1, 1'b0, 32'h10, 2'd2, 4'hF, 32'hDEAD_BEEF);
        chk("wr_word_err", {31'b0, if1.rsp.err}, 32'h0);
        chk("wr_word_rdt", if1.rsp.rdt, 32'h0);
        drv(1, 1'b1, 1'b0, 1'b0, 32'h10, 2'd2, 4'hF, 32'h0);
        chk("rd_word_rdt", if1.rsp.rdt, 32'hDEAD_BEEF);
        chk("rd_word_err", {31'b0, if1.rsp.err}, 32'h0);
        chk("sts_zero", {31'b0, if1.rsp.sts}, 32'h0);

        drv(1, 1'b1, 1'b1, 1'b0, 32'h20, 2'd2, 4'hF, 32'h0);
        drv(1, 1'b1, 1'b1, 1'b0, 32'h20, 2'd2, 4'b0101, 32'h1122_3344);
        drv(1, 1'b1, 1'b0, 1'b0, 32'h20, 2'd2, 4'hF, 32'h0);
        chk("byt_0101", if1.rsp.rdt, 32'h0022_0044);

        drv(1, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1, 4'b0011, 32'h0000_AABB);
        drv(1, 1'b1, 1'b0, 1'b0, 32'h22, 2'd1, 4'b0011, 32'h0);
        chk("ndn_half_le_rd", if1.rsp.rdt, 32'h0000_BBAA);
        drv(1, 1'b1, 1'b0, 1'b1, 32'h22, 2'd1, 4'b0011, 32'h0);
        chk("ndn_half_be_rd", if1.rsp.rdt, 32'h0000_AABB);
        drv(1, 1'b1, 1'b0, 1'b0, 32'h20, 2'd2, 4'hF, 32'h0);
        chk("word_after_half", if1.rsp.rdt, 32'hBBAA_0044);
        drv(1, 1'b1, 1'b0, 1'b0, 32'h23, 2'd0, 4'b0001, 32'h0);
        chk("byte_rd_0x23", if1.rsp.rdt, 32'h0000_00BB);

        drv(1, 1'b1, 1'b0, 1'b0, 32'd4096, 2'd2, 4'hF, 32'h0);
        chk("oor_err", {31'b0, if1.rsp.err}, 32'h1);
        chk("oor_rdt", if1.rsp.rdt, 32'h0);
        drv(1, 1'b1, 1'b1, 1'b0, 32'h13, 2'd2, 4'hF, 32'hFFFF_FFFF);
        chk("mis_wr_err", {31'b0, if1.rsp.err}, 32'h1);
        drv(1, 1'b1, 1'b0, 1'b0, 32'h10, 2'd2, 4'hF, 32'h0);
        chk("mis_wr_nochg", if1.rsp.rdt, 32'hDEAD_BEEF);
        chk("mis_wr_nochg_err", {31'b0, if1.rsp.err}, 32'h0);
        drv(1, 1'b1, 1'b0, 1'b0, 32'h21, 2'd1, 4'b0011, 32'h0);
        chk("mis_rd_err", {31'b0, if1.rsp.err}, 32'h1);
        chk("mis_rd_rdt", if1.rsp.rdt, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 32'h0);
        chk("idle_err", {31'b0, if1.rsp.err}, 32'h0);
        chk("idle_rdt", if1.rsp.rdt, 32'h0);

        // ---------------- DLY=3 instance ----------------
        for (int k = 0; k < 8; k++) begin
            drv(3, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * k), 2'd2, 4'hF, 32'hA000_0000 + 32'(k));
        end
        for (int j = 0; j < 11; j++) begin
            drv(3, (j < 8), 1'b0, 1'b0, 32'h100 + 32'(4 * j), 2'd2, 4'hF, 32'h0);
            if (j >= 2 && j < 10) begin
                chk($sformatf("pipe_rd%0d", j - 2), if3.rsp.rdt, 32'hA000_0000 + 32'(j - 2));
            end else begin
                chk($sformatf("pipe_gap%0d", j), if3.rsp.rdt, 32'h0);
            end
        end

        drv(3, 1'b1, 1'b0, 1'b0, 32'h100, 2'd2, 4'hF, 32'h0);
        drv(3, 1'b1, 1'b0, 1'b0, 32'h104, 2'd2, 4'hF, 32'h0);
        rst3 = 1'b1;
        drv(3, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 32'h0);
        chk("flush_rst", if3.rsp.rdt, 32'h0);
        rst3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(3, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 32'h0);
            chk($sformatf("flush_post%0d", i), if3.rsp.rdt, 32'h0);
        end
        drv(3, 1'b1, 1'b0, 1'b0, 32'h108, 2'd2, 4'hF, 32'h0);
        chk("post_rst_p1", if3.rsp.rdt, 32'h0);
        drv(3, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 32'h0);
        chk("post_rst_p2", if3.rsp.rdt, 32'h0);
        drv(3, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 32'h0);
        chk("post_rst_p3", if3.rsp.rdt, 32'hA000_0002);
        chk("post_rst_err", {31'b0, if3.rsp.err}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
